switches_pio_debounce: RTL and testbench



---
 rtl/switches_pio_debounce.sv | 168 ++++++++++++++++
 tb/tb_switches_pio_debounce.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/switches_pio_debounce.sv
`default_nettype none
// ============================================================================
// Module      : switches_pio_debounce
// Description : Avalon-MM slave input port for board switches and keys.
//               Each input bit passes through a two-flop synchroniser and a
//               per-bit debounce counter. Qualifying edges on the debounced
//               state are held in an edge capture register and, when
//               unmasked, raise a level interrupt.
// Ports       : clk        - system clock, rising edge
//               reset_n    - synchronous active-low reset
//               address    - register select (0 data, 1 irqmask,
//                            2 reserved, 3 edgecapture)
//               chipselect - slave select
//               write_n    - active-low write strobe
//               writedata  - write data
//               in_port    - raw asynchronous switch inputs
//               readdata   - registered read data, one cycle latency
//               irq        - level interrupt, active high
// Revision    : 1.0 - initial release
// ============================================================================
module switches_pio_debounce #(
    parameter int              WIDTH           = 8,
    parameter int              DEBOUNCE_CYCLES = 4,
    parameter int              EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] w1c_clear;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             unused_wdata;

    // Bits of writedata above WIDTH carry no meaning for this port.
    assign unused_wdata = ^writedata;

    // ------------------------------------------------------------------
    // Two-flop synchroniser
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= RESET_VALUE;
            sync2 <= RESET_VALUE;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // ------------------------------------------------------------------
    // Debounce
    // ------------------------------------------------------------------
    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // The second synchroniser flop already is the debounced state,
            // so a change is visible on the data register at edge 3.
            assign stable = sync2;
        end else begin : g_debounce
            localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                logic [CNT_W-1:0] cnt;
                logic             stable_bit;

                // The count restarts whenever the input agrees with the
                // accepted state, so only an uninterrupted run of
                // DEBOUNCE_CYCLES differing samples is accepted.
                always_ff @(posedge clk) begin
                    if (!reset_n) begin
                        cnt        <= '0;
                        stable_bit <= RESET_VALUE[i];
                    end else if (sync2[i] == stable_bit) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        stable_bit <= sync2[i];
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                assign stable[i] = stable_bit;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Edge detection and capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stable_d <= RESET_VALUE;
        end else begin
            stable_d <= stable;
        end
    end

    always_comb begin
        edge_hit = '0;
        case (EDGE_TYPE)
            0:       edge_hit = stable & ~stable_d;
            1:       edge_hit = ~stable & stable_d;
            default: edge_hit = stable ^ stable_d;
        endcase
    end

    assign wr_en     = chipselect && !write_n;
    assign w1c_clear = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    // A new edge overrides a clear issued in the same cycle so no event is lost.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            edgecapture <= '0;
            irqmask     <= '0;
        end else begin
            edgecapture <= (edgecapture & ~w1c_clear) | edge_hit;
            if (wr_en && address == ADDR_MASK) begin
                irqmask <= writedata[WIDTH-1:0];
            end
        end
    end

    assign irq = |(edgecapture & irqmask);

    // ------------------------------------------------------------------
    // Read path: registered every cycle regardless of chipselect
    // ------------------------------------------------------------------
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux[WIDTH-1:0] = stable;
            ADDR_MASK: rd_mux[WIDTH-1:0] = irqmask;
            ADDR_EDGE: rd_mux[WIDTH-1:0] = edgecapture;
            default:   rd_mux            = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_switches_pio_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_switches_pio_debounce
// Description : Directed bench for switches_pio_debounce. One instance uses
//               WIDTH=8, DEBOUNCE_CYCLES=4, rising-edge capture; a second
//               instance uses DEBOUNCE_CYCLES=0 and shares the bus inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switches_pio_debounce;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [7:0]  in_port_b;
    logic [31:0] readdata;
    logic [31:0] readdata_b;
    logic        irq;
    logic        irq_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    switches_pio_debounce #(
        .WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .RESET_VALUE(8'h00)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    switches_pio_debounce #(
        .WIDTH(8), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .RESET_VALUE(8'h00)
    ) dut_bypass (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port_b),
        .readdata(readdata_b), .irq(irq_b)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
        address = a;
        tick(1);
        check(tag, readdata, exp);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 8'h00;
        in_port_b  = 8'h00;

        // Reset / idle
        tick(3);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        check("reset_irq_bypass", {31'b0, irq_b}, 32'h0);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), "idle_read", 32'h0);
        end
        check("idle_irq", {31'b0, irq}, 32'h0);

        // Debounced step: visible at edge 3+D = 7
        address = 2'd0;
        in_port = 8'hA5;
        tick(6);
        check("step_early", readdata, 32'h0);
        tick(1);
        check("step_data", readdata, 32'h0000_00A5);
        check("step_irq_masked", {31'b0, irq}, 32'h0);
        in_port = 8'h00;
        tick(10);
        rd(2'd0, "step_return", 32'h0);
        wr(2'd3, 32'hFF);
        rd(2'd3, "step_ec_cleared", 32'h0);

        // Glitch rejection: 3-cycle pulse on bit 0
        address = 2'd0;
        in_port = 8'h01;
        tick(3);
        in_port = 8'h00;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check("glitch_data", readdata, 32'h0);
            check("glitch_irq", {31'b0, irq}, 32'h0);
        end
        rd(2'd3, "glitch_ec", 32'h0);

        // Reset while bit 0 count sits at 2 of 4
        address = 2'd0;
        in_port = 8'h01;
        tick(4);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(6);
        check("midreset_early", readdata, 32'h0);
        tick(1);
        check("midreset_data", readdata, 32'h1);
        in_port = 8'h00;
        tick(10);
        wr(2'd3, 32'hFF);

        // Edge / IRQ
        wr(2'd1, 32'h01);
        rd(2'd1, "mask_readback", 32'h01);
        in_port = 8'h01;
        tick(6);
        check("irq_early", {31'b0, irq}, 32'h0);
        tick(1);
        check("irq_set", {31'b0, irq}, 32'h1);
        in_port = 8'h03;
        tick(8);
        rd(2'd3, "ec_two_bits", 32'h03);
        check("irq_still", {31'b0, irq}, 32'h1);
        wr(2'd3, 32'h01);
        check("irq_after_w1c", {31'b0, irq}, 32'h0);
        rd(2'd3, "ec_after_w1c", 32'h02);
        wr(2'd1, 32'h02);
        check("irq_mask_bit1", {31'b0, irq}, 32'h1);
        wr(2'd1, 32'h00);
        check("irq_masked_off", {31'b0, irq}, 32'h0);
        rd(2'd3, "ec_retained", 32'h02);

        // Set-vs-clear collision on bit 2 (capture edge is edge 7)
        in_port = 8'h07;
        tick(6);
        wr(2'd3, 32'h04);
        rd(2'd3, "collision_ec", 32'h06);

        // Reserved / read-only registers and zero extension
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, "reserved_read", 32'h0);
        wr(2'd0, 32'h0000_0000);
        rd(2'd0, "data_readonly", 32'h07);
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, "mask_zero_ext", 32'h0000_00FF);
        check("irq_full_mask", {31'b0, irq}, 32'h1);

        // Bypass instance: data visible at edge 3
        address   = 2'd0;
        in_port_b = 8'h3C;
        tick(2);
        check("bypass_early", readdata_b, 32'h0);
        tick(1);
        check("bypass_data", readdata_b, 32'h0000_003C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
